// File: rtl/rv32i_pkg.sv
// Shared RV32I memory-stage definitions: widths, funct3 load/store codes,
// NOP encoding, writeback source codes, the MEM FSM state enum and the
// MEM->WB payload struct.
package rv32i_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned REG_AW = 5;
    localparam int unsigned BE_W   = 4;

    // Canonical NOP: addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSN = 32'h0000_0013;

    // funct3 (iw[14:12]) for loads and stores
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        WB_SRC_ALU = 2'b00,
        WB_SRC_RAM = 2'b01,
        WB_SRC_IO  = 2'b10
    } wb_src_e;

    typedef enum logic {
        MEM_IDLE = 1'b0,
        MEM_WAIT = 1'b1
    } mem_state_e;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   iw;
        logic [XLEN-1:0]   alu;
        logic [XLEN-1:0]   ram_data;
        logic [XLEN-1:0]   io_data;
        logic [REG_AW-1:0] wb_reg;
        logic              wb_enable;
        wb_src_e           wb_src;
    } wb_bus_t;

endpackage

// File: rtl/ls_align.sv
// Load/store lane alignment (purely combinational).
// Ports:
//   funct3    - access width/sign from the instruction word
//   addr_lo   - low two address bits selecting the byte lane
//   st_data   - raw store data (rs2)
//   ram_rdata - raw RAM read word;  ram_load - lane-selected, extended
//   io_rdata  - raw I/O read word;  io_load  - lane-selected, extended
//   be        - byte enables;       wdata    - lane-replicated store data
// Half accesses use only addr_lo[1]; a stray addr_lo[0] is truncated.
module ls_align
    import rv32i_pkg::*;
(
    input  logic [2:0]      funct3,
    input  logic [1:0]      addr_lo,
    input  logic [XLEN-1:0] st_data,
    input  logic [XLEN-1:0] ram_rdata,
    input  logic [XLEN-1:0] io_rdata,
    output logic [BE_W-1:0] be,
    output logic [XLEN-1:0] wdata,
    output logic [XLEN-1:0] ram_load,
    output logic [XLEN-1:0] io_load
);

    // Select the addressed lane and sign- or zero-extend it
    function automatic logic [XLEN-1:0] load_ext(
        input logic [2:0]      f3,
        input logic [1:0]      lo,
        input logic [XLEN-1:0] d
    );
        logic [7:0]  b;
        logic [15:0] h;
        b = d[{lo, 3'b000} +: 8];
        h = lo[1] ? d[31:16] : d[15:0];
        unique case (f3)
            F3_LB:   return {{24{b[7]}}, b};
            F3_LH:   return {{16{h[15]}}, h};
            F3_LBU:  return {24'h00_0000, b};
            F3_LHU:  return {16'h0000, h};
            default: return d;
        endcase
    endfunction

    // Byte enables and store replication by access width
    always_comb begin
        be    = 4'b1111;
        wdata = st_data;
        unique case (funct3[1:0])
            F3_SB[1:0]: begin
                be    = 4'b0001 << addr_lo;
                wdata = {4{st_data[7:0]}};
            end
            F3_SH[1:0]: begin
                be    = 4'b0011 << {addr_lo[1], 1'b0};
                wdata = {2{st_data[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wdata = st_data;
            end
        endcase
    end

    assign ram_load = load_ext(funct3, addr_lo, ram_rdata);
    assign io_load  = load_ext(funct3, addr_lo, io_rdata);

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: routes loads/stores to a handshaked RAM port or a
// single-cycle memory-mapped I/O window, stalls upstream while RAM is
// pending, and registers results for writeback.
// Ports:
//   clk, reset (sync, active-high)
//   EX inputs   : pc_in, iw_in, alu_in, rs2_data_in, wb_reg_in,
//                 wb_enable_in, mem_read_in, mem_write_in
//   stall_out   : hold upstream stages
//   RAM port    : memif_req/we/addr/wdata/be out, memif_rdata/ack in
//   I/O port    : io_we/addr/wdata/be out, io_rdata in (same-cycle)
//   WB outputs  : pc_out, iw_out, alu_out, memif_rdata_out, io_rdata_out,
//                 wb_reg_out, wb_enable_out, wb_src_out (registered)
//   Forwarding  : df_mem_enable, df_mem_reg, df_mem_data
// Build option: define MEM_ALIGN_CHECK_EN to trap misaligned half/word
// accesses and add the misalign_err_out port.
module mem_stage
    import rv32i_pkg::*;
#(
    parameter logic [31:0] IO_BASE = 32'h8000_0000,
    parameter logic [31:0] IO_SIZE = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [XLEN-1:0]   pc_in,
    input  logic [XLEN-1:0]   iw_in,
    input  logic [XLEN-1:0]   alu_in,
    input  logic [XLEN-1:0]   rs2_data_in,
    input  logic [REG_AW-1:0] wb_reg_in,
    input  logic              wb_enable_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    output logic              stall_out,
    output logic              memif_req,
    output logic              memif_we,
    output logic [XLEN-1:0]   memif_addr,
    output logic [XLEN-1:0]   memif_wdata,
    output logic [BE_W-1:0]   memif_be,
    input  logic [XLEN-1:0]   memif_rdata,
    input  logic              memif_ack,
    output logic              io_we,
    output logic [XLEN-1:0]   io_addr,
    output logic [XLEN-1:0]   io_wdata,
    output logic [BE_W-1:0]   io_be,
    input  logic [XLEN-1:0]   io_rdata,
    output logic [XLEN-1:0]   pc_out,
    output logic [XLEN-1:0]   iw_out,
    output logic [XLEN-1:0]   alu_out,
    output logic [XLEN-1:0]   memif_rdata_out,
    output logic [XLEN-1:0]   io_rdata_out,
    output logic [REG_AW-1:0] wb_reg_out,
    output logic              wb_enable_out,
    output logic [1:0]        wb_src_out,
    output logic              df_mem_enable,
    output logic [REG_AW-1:0] df_mem_reg,
    output logic [XLEN-1:0]   df_mem_data
`ifdef MEM_ALIGN_CHECK_EN
    ,
    output logic              misalign_err_out
`endif
);

    logic [2:0]      funct3;
    logic            mem_acc;
    logic            io_hit;
    logic            misalign;
    logic            ram_access;
    logic [32:0]     addr_x;
    logic [32:0]     io_lo;
    logic [32:0]     io_hi;
    logic [BE_W-1:0] lane_be;
    logic [XLEN-1:0] lane_wdata;
    logic [XLEN-1:0] ram_load;
    logic [XLEN-1:0] io_load;

    mem_state_e state_q, state_d;
    wb_bus_t    wb_q, wb_d;

    assign funct3  = iw_in[14:12];
    assign mem_acc = mem_read_in | mem_write_in;

    // 33-bit compare so a window ending at 2^32 does not wrap
    assign addr_x = {1'b0, alu_in};
    assign io_lo  = {1'b0, IO_BASE};
    assign io_hi  = {1'b0, IO_BASE} + {1'b0, IO_SIZE};
    assign io_hit = (addr_x >= io_lo) && (addr_x < io_hi);

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = mem_acc &
                      (((funct3[1:0] == F3_LH[1:0]) & alu_in[0]) |
                       ((funct3[1:0] == F3_LW[1:0]) & (|alu_in[1:0])));
`else
    assign misalign = 1'b0;
`endif

    assign ram_access = mem_acc & ~io_hit & ~misalign;

    ls_align u_ls_align (
        .funct3    (funct3),
        .addr_lo   (alu_in[1:0]),
        .st_data   (rs2_data_in),
        .ram_rdata (memif_rdata),
        .io_rdata  (io_rdata),
        .be        (lane_be),
        .wdata     (lane_wdata),
        .ram_load  (ram_load),
        .io_load   (io_load)
    );

    // RAM request FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, request and stall; upstream holds inputs while stalled
    always_comb begin
        state_d   = state_q;
        memif_req = 1'b0;
        stall_out = 1'b0;
        unique case (state_q)
            MEM_IDLE: begin
                memif_req = ram_access;
                stall_out = ram_access & ~memif_ack;
                if (ram_access & ~memif_ack) begin
                    state_d = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                memif_req = 1'b1;
                stall_out = ram_access & ~memif_ack;
                if (memif_ack) begin
                    state_d = MEM_IDLE;
                end
            end
        endcase
    end

    assign memif_we    = mem_write_in;
    assign memif_addr  = {alu_in[31:2], 2'b00};
    assign memif_wdata = lane_wdata;
    assign memif_be    = lane_be;

    assign io_we    = mem_write_in & io_hit & ~misalign;
    assign io_addr  = alu_in;
    assign io_wdata = lane_wdata;
    assign io_be    = lane_be;

    // Loads are not forwardable: their data is not known here yet
    assign df_mem_enable = wb_enable_in & ~mem_read_in;
    assign df_mem_reg    = wb_reg_in;
    assign df_mem_data   = alu_in;

    // WB payload: bubble while stalled, else the current instruction
    always_comb begin
        wb_d = '0;
        if (stall_out) begin
            wb_d.iw = NOP_INSN;
        end else begin
            wb_d.pc        = pc_in;
            wb_d.iw        = iw_in;
            wb_d.alu       = alu_in;
            wb_d.ram_data  = ram_load;
            wb_d.io_data   = io_load;
            wb_d.wb_reg    = wb_reg_in;
            wb_d.wb_enable = wb_enable_in & ~misalign;
            if (mem_read_in) begin
                wb_d.wb_src = io_hit ? WB_SRC_IO : WB_SRC_RAM;
            end else begin
                wb_d.wb_src = WB_SRC_ALU;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wb_q <= '0;
        end else begin
            wb_q <= wb_d;
        end
    end

    assign pc_out          = wb_q.pc;
    assign iw_out          = wb_q.iw;
    assign alu_out         = wb_q.alu;
    assign memif_rdata_out = wb_q.ram_data;
    assign io_rdata_out    = wb_q.io_data;
    assign wb_reg_out      = wb_q.wb_reg;
    assign wb_enable_out   = wb_q.wb_enable;
    assign wb_src_out      = wb_q.wb_src;

`ifdef MEM_ALIGN_CHECK_EN
    logic misalign_q;
    logic misalign_d;

    assign misalign_d = misalign;

    // One-cycle error pulse aligned with the WB outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign misalign_err_out = misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed vector table, hand-written
// multi-cycle sequences (wait states, reset in WAIT, misalignment), and
// randomized transactions checked against an arithmetic reference model.
module tb_mem_stage;

    localparam logic [31:0] IO_BASE = 32'h8000_0000;
    localparam logic [31:0] IO_SIZE = 32'h0000_1000;
    localparam logic [31:0] NOP     = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_in, iw_in, alu_in, rs2_data_in;
    logic [4:0]  wb_reg_in;
    logic        wb_enable_in, mem_read_in, mem_write_in;
    logic        stall_out;
    logic        memif_req, memif_we;
    logic [31:0] memif_addr, memif_wdata;
    logic [3:0]  memif_be;
    logic [31:0] memif_rdata;
    logic        memif_ack;
    logic        io_we;
    logic [31:0] io_addr, io_wdata;
    logic [3:0]  io_be;
    logic [31:0] io_rdata;
    logic [31:0] pc_out, iw_out, alu_out, memif_rdata_out, io_rdata_out;
    logic [4:0]  wb_reg_out;
    logic        wb_enable_out;
    logic [1:0]  wb_src_out;
    logic        df_mem_enable;
    logic [4:0]  df_mem_reg;
    logic [31:0] df_mem_data;
`ifdef MEM_ALIGN_CHECK_EN
    logic        misalign_err_out;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_stage #(.IO_BASE(IO_BASE), .IO_SIZE(IO_SIZE)) dut (
        .clk             (clk),
        .reset           (reset),
        .pc_in           (pc_in),
        .iw_in           (iw_in),
        .alu_in          (alu_in),
        .rs2_data_in     (rs2_data_in),
        .wb_reg_in       (wb_reg_in),
        .wb_enable_in    (wb_enable_in),
        .mem_read_in     (mem_read_in),
        .mem_write_in    (mem_write_in),
        .stall_out       (stall_out),
        .memif_req       (memif_req),
        .memif_we        (memif_we),
        .memif_addr      (memif_addr),
        .memif_wdata     (memif_wdata),
        .memif_be        (memif_be),
        .memif_rdata     (memif_rdata),
        .memif_ack       (memif_ack),
        .io_we           (io_we),
        .io_addr         (io_addr),
        .io_wdata        (io_wdata),
        .io_be           (io_be),
        .io_rdata        (io_rdata),
        .pc_out          (pc_out),
        .iw_out          (iw_out),
        .alu_out         (alu_out),
        .memif_rdata_out (memif_rdata_out),
        .io_rdata_out    (io_rdata_out),
        .wb_reg_out      (wb_reg_out),
        .wb_enable_out   (wb_enable_out),
        .wb_src_out      (wb_src_out),
        .df_mem_enable   (df_mem_enable),
        .df_mem_reg      (df_mem_reg),
        .df_mem_data     (df_mem_data)
`ifdef MEM_ALIGN_CHECK_EN
        ,
        .misalign_err_out(misalign_err_out)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic int unsigned acc_size(input logic [2:0] f3);
        if (f3[1:0] == 2'd0) return 1;
        if (f3[1:0] == 2'd1) return 2;
        return 4;
    endfunction

    // byte offset of the access after truncating to its natural alignment
    function automatic int unsigned lane_off(input logic [2:0] f3, input logic [31:0] a);
        int unsigned sz;
        sz = acc_size(f3);
        return ((a % 4) / sz) * sz;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int unsigned v;
        v = ((1 << acc_size(f3)) - 1) << lane_off(f3, a);
        return 4'(v);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rs2);
        logic [31:0] r;
        int unsigned sz;
        sz = acc_size(f3);
        for (int i = 0; i < 4; i++) r[8*i +: 8] = rs2[8*(i % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] d);
        longint unsigned v, mask;
        int unsigned sz;
        sz = acc_size(f3);
        v  = {32'h0, d} >> (8 * lane_off(f3, a));
        if (sz < 4) begin
            mask = (64'd1 << (8 * sz)) - 64'd1;
            v    = v & mask;
            if (!f3[2] && v >= (mask + 64'd1) / 64'd2) v = v | ~mask;
        end
        return 32'(v);
    endfunction

    function automatic bit model_io_hit(input logic [31:0] a);
        longint unsigned x;
        x = {32'h0, a};
        return (x >= {32'h0, IO_BASE}) && (x < ({32'h0, IO_BASE} + {32'h0, IO_SIZE}));
    endfunction

    function automatic logic [31:0] mk_iw(input logic [2:0] f3, input bit st);
        return {17'h0, f3, 5'd3, st ? 7'h23 : 7'h03};
    endfunction

    task automatic clear_inputs();
        pc_in = '0; iw_in = '0; alu_in = '0; rs2_data_in = '0; wb_reg_in = '0;
        wb_enable_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
        memif_rdata = '0; memif_ack = 1'b0; io_rdata = '0;
    endtask

    // Apply one instruction, ack RAM after 'waits' stall cycles, check all
    task automatic do_txn(input logic [31:0] pc, input logic [31:0] iw, input logic [31:0] alu,
                          input logic [31:0] rs2, input logic [4:0] rd_reg, input logic wen,
                          input logic rd, input logic wr, input logic [31:0] ram_data,
                          input logic [31:0] io_data, input int waits_in);
        bit io, ram;
        int waits;
        logic [2:0] f3;
        f3  = iw[14:12];
        io  = model_io_hit(alu);
        ram = (rd || wr) && !io;
        waits = ram ? waits_in : 0;
        pc_in = pc; iw_in = iw; alu_in = alu; rs2_data_in = rs2; wb_reg_in = rd_reg;
        wb_enable_in = wen; mem_read_in = rd; mem_write_in = wr; io_rdata = io_data;
        for (int k = 0; k <= waits; k++) begin
            memif_ack   = (k == waits);
            memif_rdata = (k == waits) ? ram_data : 32'($urandom);
            #2;
            chk("stall_out", 32'(stall_out), 32'(ram && k < waits));
            chk("memif_req", 32'(memif_req), 32'(ram));
            if (ram) begin
                chk("memif_addr", memif_addr, alu & 32'hFFFF_FFFC);
                chk("memif_we", 32'(memif_we), 32'(wr));
                chk("memif_be", 32'(memif_be), 32'(model_be(f3, alu)));
                if (wr) chk("memif_wdata", memif_wdata, model_wdata(f3, rs2));
            end
            chk("io_we", 32'(io_we), 32'(wr && io));
            if (io && wr) begin
                chk("io_addr", io_addr, alu);
                chk("io_be", 32'(io_be), 32'(model_be(f3, alu)));
                chk("io_wdata", io_wdata, model_wdata(f3, rs2));
            end
            chk("df_mem_enable", 32'(df_mem_enable), 32'(wen && !rd));
            chk("df_mem_data", df_mem_data, alu);
            @(posedge clk);
            #1;
            if (k < waits) begin
                chk("bubble_wb_enable", 32'(wb_enable_out), 32'd0);
                chk("bubble_iw", iw_out, NOP);
                chk("bubble_pc", pc_out, 32'd0);
            end else begin
                chk("pc_out", pc_out, pc);
                chk("iw_out", iw_out, iw);
                chk("alu_out", alu_out, alu);
                chk("wb_reg_out", 32'(wb_reg_out), 32'(rd_reg));
                chk("wb_enable_out", 32'(wb_enable_out), 32'(wen));
                chk("wb_src_out", 32'(wb_src_out), rd ? (io ? 32'd2 : 32'd1) : 32'd0);
                chk("memif_rdata_out", memif_rdata_out, model_load(f3, alu, ram_data));
                chk("io_rdata_out", io_rdata_out, model_load(f3, alu, io_data));
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic        rd;
        logic        wr;
        logic [31:0] ram;
        logic [31:0] io;
        logic        exp_req;
        logic        exp_iowe;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [1:0]  exp_src;
        logic [31:0] exp_mem;
        logic [31:0] exp_io;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int stall_cnt;
        int ld_f3[5];
        reset = 1'b1;
        clear_inputs();

        vecs[0] = '{3'b000, 32'h0000_0102, 32'h0000_00AB, 1'b0, 1'b1, 32'h0, 32'h0,
                    1'b1, 1'b0, 4'b0100, 32'hABAB_ABAB, 2'b00, 32'h0, 32'h0};
        vecs[1] = '{3'b101, 32'h8000_0002, 32'h0, 1'b1, 1'b0, 32'h0, 32'hBEEF_0000,
                    1'b0, 1'b0, 4'b1100, 32'h0, 2'b10, 32'h0, 32'h0000_BEEF};
        vecs[2] = '{3'b010, 32'h0000_0200, 32'h0, 1'b1, 1'b0, 32'h1234_5678, 32'h0,
                    1'b1, 1'b0, 4'b1111, 32'h0, 2'b01, 32'h1234_5678, 32'h0};
        vecs[3] = '{3'b001, 32'h0000_0206, 32'h0, 1'b1, 1'b0, 32'h8001_7FFF, 32'h0,
                    1'b1, 1'b0, 4'b1100, 32'h0, 2'b01, 32'hFFFF_8001, 32'h0};
        vecs[4] = '{3'b100, 32'h0000_0201, 32'h0, 1'b1, 1'b0, 32'h0000_F000, 32'h0,
                    1'b1, 1'b0, 4'b0010, 32'h0, 2'b01, 32'h0000_00F0, 32'h0};
        vecs[5] = '{3'b001, 32'h0000_0304, 32'h1234_CAFE, 1'b0, 1'b1, 32'h0, 32'h0,
                    1'b1, 1'b0, 4'b0011, 32'hCAFE_CAFE, 2'b00, 32'h0, 32'h0};
        vecs[6] = '{3'b010, 32'h8000_0FFC, 32'hDEAD_BEEF, 1'b0, 1'b1, 32'h0, 32'h0,
                    1'b0, 1'b1, 4'b1111, 32'hDEAD_BEEF, 2'b00, 32'h0, 32'h0};
        vecs[7] = '{3'b010, 32'h8000_1000, 32'h0, 1'b1, 1'b0, 32'hA5A5_0001, 32'h0,
                    1'b1, 1'b0, 4'b1111, 32'h0, 2'b01, 32'hA5A5_0001, 32'h0};
        vecs[8] = '{3'b000, 32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 32'h7F00_0000, 32'h0,
                    1'b1, 1'b0, 4'b1000, 32'h0, 2'b01, 32'h0000_007F, 32'h0};
        vecs[9] = '{3'b000, 32'h8000_0FFF, 32'h0, 1'b1, 1'b0, 32'h0, 32'h8000_0000,
                    1'b0, 1'b0, 4'b1000, 32'h0, 2'b10, 32'h0, 32'hFFFF_FF80};

        repeat (2) @(posedge clk);
        #1;
        // reset state
        chk("rst_pc_out", pc_out, 32'h0);
        chk("rst_iw_out", iw_out, 32'h0);
        chk("rst_alu_out", alu_out, 32'h0);
        chk("rst_wb_enable", 32'(wb_enable_out), 32'h0);
        chk("rst_wb_src", 32'(wb_src_out), 32'h0);
        chk("rst_memif_rdata_out", memif_rdata_out, 32'h0);
        chk("rst_io_rdata_out", io_rdata_out, 32'h0);
        reset = 1'b0;
        #1;
        chk("rst_memif_req", 32'(memif_req), 32'h0);
        chk("rst_stall", 32'(stall_out), 32'h0);

        // directed vectors, zero-wait acks
        for (int i = 0; i < 10; i++) begin
            pc_in = 32'h1000 + 32'(4 * i);
            iw_in = mk_iw(vecs[i].f3, vecs[i].wr);
            alu_in = vecs[i].addr; rs2_data_in = vecs[i].rs2; wb_reg_in = 5'd3;
            wb_enable_in = vecs[i].rd; mem_read_in = vecs[i].rd; mem_write_in = vecs[i].wr;
            memif_rdata = vecs[i].ram; io_rdata = vecs[i].io; memif_ack = 1'b1;
            #2;
            chk($sformatf("v%0d_stall", i), 32'(stall_out), 32'h0);
            chk($sformatf("v%0d_req", i), 32'(memif_req), 32'(vecs[i].exp_req));
            chk($sformatf("v%0d_io_we", i), 32'(io_we), 32'(vecs[i].exp_iowe));
            chk($sformatf("v%0d_memif_be", i), 32'(memif_be), 32'(vecs[i].exp_be));
            chk($sformatf("v%0d_io_be", i), 32'(io_be), 32'(vecs[i].exp_be));
            chk($sformatf("v%0d_wdata", i), memif_wdata, vecs[i].exp_wdata);
            chk($sformatf("v%0d_addr", i), memif_addr, vecs[i].addr & 32'hFFFF_FFFC);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_pc_out", i), pc_out, 32'h1000 + 32'(4 * i));
            chk($sformatf("v%0d_wb_en", i), 32'(wb_enable_out), 32'(vecs[i].rd));
            chk($sformatf("v%0d_wb_src", i), 32'(wb_src_out), 32'(vecs[i].exp_src));
            chk($sformatf("v%0d_mem_out", i), memif_rdata_out, vecs[i].exp_mem);
            chk($sformatf("v%0d_io_out", i), io_rdata_out, vecs[i].exp_io);
        end

        // LB 0x203 acked after 3 wait cycles
        pc_in = 32'h2000; iw_in = mk_iw(3'b000, 1'b0); alu_in = 32'h0000_0203;
        rs2_data_in = '0; wb_reg_in = 5'd7; wb_enable_in = 1'b1;
        mem_read_in = 1'b1; mem_write_in = 1'b0; io_rdata = '0;
        stall_cnt = 0;
        for (int k = 0; k <= 3; k++) begin
            memif_ack   = (k == 3);
            memif_rdata = (k == 3) ? 32'h80AB_CDEF : 32'($urandom);
            #2;
            if (stall_out) stall_cnt++;
            chk("lb_wait_req", 32'(memif_req), 32'h1);
            chk("lb_wait_addr", memif_addr, 32'h0000_0200);
            @(posedge clk);
            #1;
            if (k < 3) begin
                chk("lb_bubble_en", 32'(wb_enable_out), 32'h0);
                chk("lb_bubble_iw", iw_out, NOP);
                chk("lb_bubble_pc", pc_out, 32'h0);
            end
        end
        chk("lb_stall_cycles", 32'(stall_cnt), 32'd3);
        chk("lb_mem_out", memif_rdata_out, 32'hFFFF_FF80);
        chk("lb_wb_src", 32'(wb_src_out), 32'h1);
        chk("lb_wb_en", 32'(wb_enable_out), 32'h1);
        chk("lb_pc_out", pc_out, 32'h2000);

        // reset while waiting; late ack must be ignored
        pc_in = 32'h3000; iw_in = mk_iw(3'b010, 1'b0); alu_in = 32'h0000_0400;
        wb_reg_in = 5'd9; wb_enable_in = 1'b1; mem_read_in = 1'b1; memif_ack = 1'b0;
        #2;
        chk("rw_stall", 32'(stall_out), 32'h1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        reset = 1'b0;
        memif_ack = 1'b1;
        #1;
        chk("rw_req_after_reset", 32'(memif_req), 32'h0);
        chk("rw_stall_after_reset", 32'(stall_out), 32'h0);
        chk("rw_pc_out", pc_out, 32'h0);
        chk("rw_iw_out", iw_out, 32'h0);
        chk("rw_wb_en", 32'(wb_enable_out), 32'h0);
        chk("rw_wb_reg", 32'(wb_reg_out), 32'h0);
        @(posedge clk);
        #1;
        memif_ack = 1'b0;
        chk("rw_late_ack_wb_en", 32'(wb_enable_out), 32'h0);
        chk("rw_late_ack_wb_src", 32'(wb_src_out), 32'h0);
        chk("rw_late_ack_pc", pc_out, 32'h0);

        // misaligned LW at 0x101
        pc_in = 32'h4000; iw_in = mk_iw(3'b010, 1'b0); alu_in = 32'h0000_0101;
        wb_reg_in = 5'd4; wb_enable_in = 1'b1; mem_read_in = 1'b1;
        memif_rdata = 32'h1122_3344; memif_ack = 1'b1;
        #2;
        chk("mis_stall", 32'(stall_out), 32'h0);
`ifdef MEM_ALIGN_CHECK_EN
        chk("mis_req", 32'(memif_req), 32'h0);
        @(posedge clk);
        #1;
        chk("mis_err_pulse", 32'(misalign_err_out), 32'h1);
        chk("mis_wb_en", 32'(wb_enable_out), 32'h0);
        clear_inputs();
        @(posedge clk);
        #1;
        chk("mis_err_clear", 32'(misalign_err_out), 32'h0);
`else
        chk("mis_req", 32'(memif_req), 32'h1);
        chk("mis_be", 32'(memif_be), 32'hF);
        chk("mis_addr", memif_addr, 32'h0000_0100);
        @(posedge clk);
        #1;
        chk("mis_wb_en", 32'(wb_enable_out), 32'h1);
        chk("mis_mem_out", memif_rdata_out, 32'h1122_3344);
        clear_inputs();
`endif

        // randomized transactions against the reference model
        ld_f3 = '{0, 1, 2, 4, 5};
        for (int t = 0; t < 150; t++) begin
            int kind;
            logic [2:0] f3;
            logic [31:0] a, iw;
            logic rd, wr;
            kind = $urandom_range(0, 4);
            rd = (kind == 1) || (kind == 3);
            wr = (kind == 2) || (kind == 4);
            f3 = rd ? 3'(ld_f3[$urandom_range(0, 4)]) : 3'($urandom_range(0, 2));
            if (kind >= 3) a = IO_BASE + 32'($urandom_range(0, 32'(IO_SIZE) - 1));
            else           a = 32'($urandom) & 32'h7FFF_FFFF;
            if (kind == 0) a = 32'($urandom);
`ifdef MEM_ALIGN_CHECK_EN
            a = a & ~32'(acc_size(f3) - 1);
`endif
            iw = 32'($urandom);
            iw[14:12] = f3;
            do_txn(32'($urandom), iw, a, 32'($urandom), 5'($urandom), 1'($urandom),
                   rd, wr, 32'($urandom), 32'($urandom), $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
